pulse_param_loader: RTL
=======================

Name: pulse_param_loader

Overview:
Upstream stage of the pulse generator. It consumes the byte stream from the PC link's UART receiver and parses fixed-length, checksummed parameter frames. On a good frame it updates the full pulse-parameter set atomically, so the generator only ever sees coherent values. All logic runs on the 50 MHz clk domain. Its outputs feed the generator's per/p1wid/del/p2wid/nut_w/nut_d/cp/p_bl/p_bl_off/bl inputs, and load_stb replaces the generator's rx_done.

Parameters:
HEADER, 8'hA5, frame start byte
TIMEOUT_CYCLES, 500000, inter-byte timeout in clk cycles (10 ms at 50 MHz); counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  50 MHz system clock
reset  in  1  synchronous, active-high reset (one clock; polarity and synchronicity fixed)
rx_data  in  8  received byte, valid when rx_valid=1
rx_valid  in  1  single-cycle strobe per received byte
per  out  32  period, cycles
p1wid  out  16  pulse 1 width
del  out  16  inter-pulse delay
p2wid  out  16  pulse 2 / CPMG pulse width
nut_w  out  8  nutation pulse width
nut_d  out  16  nutation pulse end offset from period end
cp  out  8  0=CW, 1=Hahn, N>1=CPMG with N pulses
p_bl  out  8  block-open start after pulse
p_bl_off  out  16  block-open end after pulse
bl  out  1  blocking enable
load_stb  out  1  one-cycle strobe: new parameter set committed
err_stb  out  1  one-cycle strobe: frame rejected (checksum, per==0, or timeout)
busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Frame format: HEADER, then 18 payload bytes, then 1 checksum byte. Multi-byte fields are big-endian.
- Payload order: per[4], p1wid[2], del[2], p2wid[2], nut_w[1], nut_d[2], cp[1], p_bl[1], p_bl_off[2], bl[1]. For bl, only bit 0 is used; bits 7:1 are ignored.
- Checksum: 8-bit sum, mod 256, of the 18 payload bytes. The header is excluded.
- Reset values: per=20000, p1wid=30, del=200, p2wid=60, nut_w=0, nut_d=0, cp=1, p_bl=50, p_bl_off=100, bl=1. load_stb=0, err_stb=0, busy=0, state=IDLE, index=0, running sum=0.
- FSM states: IDLE, PAYLOAD, CHECK.
  - IDLE: rx_valid with rx_data==HEADER moves to PAYLOAD with index=0 and sum=0. Any other byte is silently discarded.
  - PAYLOAD: each rx_valid writes the byte into shadow buffer slot [index] and adds it to sum. After byte index 17, go to CHECK.
  - CHECK: the next rx_valid is the checksum byte, and the FSM returns to IDLE.
- Commit: the checksum byte is accepted at cycle N. If it equals sum and the shadow per != 0, all ten outputs update at N+1 and load_stb=1 at N+1 only. Otherwise the outputs hold and err_stb=1 at N+1.
- Outputs change only on commit or reset. Partial updates never occur.
- A HEADER value inside PAYLOAD or CHECK is treated as data; there is no resync mid-frame.
- Timeout: the counter clears on every accepted byte and counts while in PAYLOAD or CHECK. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, err_stb is pulsed for one cycle, and outputs hold.
- Simultaneous rx_valid and timeout expiry: the byte wins; it is accepted and the counter clears.
- Back-to-back frames: a HEADER arriving the cycle after the checksum (FSM in IDLE) starts the new frame normally. A pending load_stb still fires.
- Reset mid-frame: shadow buffer contents are discarded, outputs return to the reset values, and no strobe is issued.
- The running sum wraps mod 256. The index saturates and cannot overflow past 17.

Decomposition:
- Shared package pulses_pkg holds: HEADER, PAYLOAD_LEN=18, the byte offsets of each field, and the reset default values. The pulse generator also uses these defaults.
- One natural sub-module: frame_rx_fsm (IDLE/PAYLOAD/CHECK, index, running sum, timeout counter). It emits byte_wr/index/frame_ok/frame_err. The top level holds the shadow buffer and output registers.

Test Plan:
1. After reset, with no input: per=20000, p1wid=30, del=200, p2wid=60, cp=1, bl=1, strobes=0.
2. Send a good frame with per=0x00004E20→0x00009C40, p1wid=40, del=300, p2wid=80, cp=3, bl=0 and correct checksum. Required: exactly one load_stb, the cycle after the checksum byte, with all fields updated that same cycle.
3. Send the same frame with checksum+1. Required: err_stb for one cycle and all outputs unchanged. Then send a good frame: load_stb and the new values.
4. Send HEADER plus 7 payload bytes, then idle TIMEOUT_CYCLES cycles. Required: err_stb once and busy=0. Then send a complete good frame: it is accepted.
5. Send 0x13, 0x00, 0xFF, then a good frame whose payload contains 0xA5 bytes. Required: garbage ignored, frame accepted, 0xA5 payload bytes stored as data.
6. Assert reset after 10 payload bytes of a frame, following an earlier committed frame. Required: outputs return to the defaults and no strobe. Then send two frames back to back: two load_stb pulses, with the final values from the second frame.

Source files
------------

// File: rtl/pulses_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : pulses_pkg                                                       |
// | Purpose : Shared constants for the pulse-parameter link and the pulse      |
// |           generator: frame header, payload layout (byte offsets of every   |
// |           field), receiver FSM state encoding, the parameter-set struct    |
// |           and its power-on defaults.                                       |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package pulses_pkg;

   // Frame layout
   localparam logic [7:0] HEADER      = 8'hA5;
   localparam int         PAYLOAD_LEN = 18;
   localparam int         IDX_W       = $clog2(PAYLOAD_LEN);

   // Byte offsets of each field inside the payload (big-endian fields)
   localparam int OFF_PER      = 0;   // 4 bytes
   localparam int OFF_P1WID    = 4;   // 2 bytes
   localparam int OFF_DEL      = 6;   // 2 bytes
   localparam int OFF_P2WID    = 8;   // 2 bytes
   localparam int OFF_NUT_W    = 10;  // 1 byte
   localparam int OFF_NUT_D    = 11;  // 2 bytes
   localparam int OFF_CP       = 13;  // 1 byte
   localparam int OFF_P_BL     = 14;  // 1 byte
   localparam int OFF_P_BL_OFF = 15;  // 2 bytes
   localparam int OFF_BL       = 17;  // 1 byte, bit 0 only

   // Receiver FSM state encoding
   typedef logic [1:0] rx_state_t;
   localparam rx_state_t ST_IDLE    = 2'd0;
   localparam rx_state_t ST_PAYLOAD = 2'd1;
   localparam rx_state_t ST_CHECK   = 2'd2;

   // Complete pulse-parameter set, committed atomically
   typedef struct packed {
      logic [31:0] per;
      logic [15:0] p1wid;
      logic [15:0] del;
      logic [15:0] p2wid;
      logic [7:0]  nut_w;
      logic [15:0] nut_d;
      logic [7:0]  cp;
      logic [7:0]  p_bl;
      logic [15:0] p_bl_off;
      logic        bl;
   } pulse_params_t;

   // Power-on defaults, also used by the pulse generator
   localparam logic [31:0] DEF_PER      = 32'd20000;
   localparam logic [15:0] DEF_P1WID    = 16'd30;
   localparam logic [15:0] DEF_DEL      = 16'd200;
   localparam logic [15:0] DEF_P2WID    = 16'd60;
   localparam logic [7:0]  DEF_NUT_W    = 8'd0;
   localparam logic [15:0] DEF_NUT_D    = 16'd0;
   localparam logic [7:0]  DEF_CP       = 8'd1;
   localparam logic [7:0]  DEF_P_BL     = 8'd50;
   localparam logic [15:0] DEF_P_BL_OFF = 16'd100;
   localparam logic        DEF_BL       = 1'b1;

   localparam pulse_params_t DEF_PARAMS = '{
      per      : DEF_PER,
      p1wid    : DEF_P1WID,
      del      : DEF_DEL,
      p2wid    : DEF_P2WID,
      nut_w    : DEF_NUT_W,
      nut_d    : DEF_NUT_D,
      cp       : DEF_CP,
      p_bl     : DEF_P_BL,
      p_bl_off : DEF_P_BL_OFF,
      bl       : DEF_BL
   };

   // Join two bytes into a big-endian 16-bit field
   function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_rx_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : frame_rx_fsm                                                     |
// | Purpose : Frame parser for the parameter link. Tracks IDLE/PAYLOAD/CHECK,  |
// |           the payload byte index, the running mod-256 checksum and the     |
// |           inter-byte timeout. Reports each payload byte write and the      |
// |           verdict of every frame.                                          |
// | Ports   : clk, reset        - clock, synchronous active-high reset         |
// |           rx_data, rx_valid - received byte and its one-cycle strobe       |
// |           payload_ok        - shadow payload is acceptable (per != 0)      |
// |           byte_wr, index    - write rx_data into shadow slot [index]       |
// |           frame_ok          - checksum byte matched, commit this cycle     |
// |           frame_err         - checksum/content error or timeout            |
// |           busy              - frame in progress                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module frame_rx_fsm
   import pulses_pkg::*;
#(
   parameter logic [7:0] HEADER         = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             payload_ok,
   output logic             byte_wr,
   output logic [IDX_W-1:0] index,
   output logic             frame_ok,
   output logic             frame_err,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

   rx_state_t        state;
   rx_state_t        state_next;
   logic [7:0]       sum;
   logic [CNT_W-1:0] tcnt;
   logic             tmo_hit;

   // A byte arriving in the expiry cycle wins over the timeout
   assign tmo_hit = (state != ST_IDLE) && !rx_valid && (tcnt == TMO_MAX);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Index, running checksum and timeout counter
   always_ff @(posedge clk) begin
      if (reset) begin
         index <= '0;
         sum   <= '0;
         tcnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               tcnt <= '0;
               if (rx_valid && rx_data == HEADER) begin
                  index <= '0;
                  sum   <= '0;
               end
            end
            ST_PAYLOAD: begin
               if (rx_valid) begin
                  sum  <= sum + rx_data;
                  tcnt <= '0;
                  // Saturate at the last slot so the shadow write can never overrun
                  if (index != LAST_IDX) begin
                     index <= index + 1'b1;
                  end
               end else if (tcnt != TMO_MAX) begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_CHECK: begin
               if (rx_valid) begin
                  tcnt <= '0;
               end else if (tcnt != TMO_MAX) begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: begin
               tcnt <= '0;
            end
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (rx_valid && rx_data == HEADER) begin
               state_next = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (rx_valid && index == LAST_IDX) begin
               state_next = ST_CHECK;
            end else if (tmo_hit) begin
               state_next = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (rx_valid || tmo_hit) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      byte_wr   = 1'b0;
      frame_ok  = 1'b0;
      frame_err = tmo_hit;
      busy      = (state != ST_IDLE);
      case (state)
         ST_PAYLOAD: begin
            byte_wr = rx_valid;
         end
         ST_CHECK: begin
            if (rx_valid) begin
               if (rx_data == sum && payload_ok) begin
                  frame_ok = 1'b1;
               end else begin
                  frame_err = 1'b1;
               end
            end
         end
         default: begin
            byte_wr = 1'b0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/pulse_param_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pulse_param_loader                                               |
// | Purpose : Parses checksummed parameter frames from the UART byte stream    |
// |           and commits the full pulse-parameter set atomically on a good    |
// |           frame, so the generator only ever sees coherent values.          |
// | Ports   : clk, reset        - 50 MHz clock, synchronous active-high reset  |
// |           rx_data, rx_valid - received byte and its one-cycle strobe       |
// |           per .. bl         - committed pulse parameters                   |
// |           load_stb          - one-cycle strobe, new set committed          |
// |           err_stb           - one-cycle strobe, frame rejected             |
// |           busy              - frame in progress                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pulse_param_loader
   import pulses_pkg::*;
#(
   parameter logic [7:0] HEADER         = pulses_pkg::HEADER,
   parameter int         TIMEOUT_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] per,
   output logic [15:0] p1wid,
   output logic [15:0] del,
   output logic [15:0] p2wid,
   output logic [7:0]  nut_w,
   output logic [15:0] nut_d,
   output logic [7:0]  cp,
   output logic [7:0]  p_bl,
   output logic [15:0] p_bl_off,
   output logic        bl,
   output logic        load_stb,
   output logic        err_stb,
   output logic        busy
);

   logic             byte_wr;
   logic [IDX_W-1:0] index;
   logic             frame_ok;
   logic             frame_err;
   logic             payload_ok;

   logic [7:0]       shadow [PAYLOAD_LEN];
   pulse_params_t    shadow_params;
   pulse_params_t    params;

   frame_rx_fsm #(
      .HEADER         (HEADER),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx_fsm (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .payload_ok (payload_ok),
      .byte_wr    (byte_wr),
      .index      (index),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   // Shadow buffer: collects the payload; cleared on reset so an aborted
   // frame leaves nothing behind
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PAYLOAD_LEN; i++) begin
            shadow[i] <= '0;
         end
      end else if (byte_wr) begin
         shadow[index] <= rx_data;
      end
   end

   // Field view of the shadow buffer
   always_comb begin
      shadow_params          = DEF_PARAMS;
      shadow_params.per      = {shadow[OFF_PER], shadow[OFF_PER+1],
                                shadow[OFF_PER+2], shadow[OFF_PER+3]};
      shadow_params.p1wid    = be16(shadow[OFF_P1WID], shadow[OFF_P1WID+1]);
      shadow_params.del      = be16(shadow[OFF_DEL], shadow[OFF_DEL+1]);
      shadow_params.p2wid    = be16(shadow[OFF_P2WID], shadow[OFF_P2WID+1]);
      shadow_params.nut_w    = shadow[OFF_NUT_W];
      shadow_params.nut_d    = be16(shadow[OFF_NUT_D], shadow[OFF_NUT_D+1]);
      shadow_params.cp       = shadow[OFF_CP];
      shadow_params.p_bl     = shadow[OFF_P_BL];
      shadow_params.p_bl_off = be16(shadow[OFF_P_BL_OFF], shadow[OFF_P_BL_OFF+1]);
      // Only bit 0 of the blocking byte is meaningful
      shadow_params.bl       = ((shadow[OFF_BL] & 8'h01) != 8'h00);
   end

   // A zero period would stall the generator, so such frames are rejected
   assign payload_ok = (shadow_params.per != 32'd0);

   // Output registers: the whole set moves in a single edge
   always_ff @(posedge clk) begin
      if (reset) begin
         params   <= DEF_PARAMS;
         load_stb <= 1'b0;
         err_stb  <= 1'b0;
      end else begin
         load_stb <= frame_ok;
         err_stb  <= frame_err;
         if (frame_ok) begin
            params <= shadow_params;
         end
      end
   end

   assign per      = params.per;
   assign p1wid    = params.p1wid;
   assign del      = params.del;
   assign p2wid    = params.p2wid;
   assign nut_w    = params.nut_w;
   assign nut_d    = params.nut_d;
   assign cp       = params.cp;
   assign p_bl     = params.p_bl;
   assign p_bl_off = params.p_bl_off;
   assign bl       = params.bl;

endmodule
`default_nettype wire
